// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C slave definitions: frame sizes, FSM states, address match helper
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_FRAME_BITS = 8;
  localparam logic [I2C_ADDR_W-1:0] I2C_GEN_CALL_ADDR = 7'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ACK_WAIT,
    ST_ACK,
    ST_SELECTED,
    ST_IGNORE
  } slave_state_e;

  // Own-address hit, optionally widened to accept the general call address
  function automatic logic addr_hit(
    input logic [I2C_ADDR_W-1:0] rx_addr,
    input logic [I2C_ADDR_W-1:0] own_addr,
    input logic                  gen_call_en
  );
    return (rx_addr == own_addr) || (gen_call_en && (rx_addr == I2C_GEN_CALL_ADDR));
  endfunction

endpackage

// File: rtl/slave_addr_sipo_match_if.sv
// rtl/slave_addr_sipo_match_if.sv - bus pins and address-phase results of the slave address receiver
interface slave_addr_sipo_match_if;
  import i2c_pkg::*;

  logic                  slave_scl;
  logic                  slave_sda;
  logic [I2C_ADDR_W-1:0] slave_own_address;
  logic                  slave_sda_ack_oe;
  logic [I2C_ADDR_W-1:0] slave_rx_addr;
  logic                  slave_rd_wr;
  logic                  slave_addr_valid;
  logic                  slave_addr_match;
  logic                  slave_selected;
  logic                  slave_busy;

  modport slave (
    input  slave_scl, slave_sda, slave_own_address,
    output slave_sda_ack_oe, slave_rx_addr, slave_rd_wr, slave_addr_valid,
           slave_addr_match, slave_selected, slave_busy
  );

  modport master (
    output slave_scl, slave_sda, slave_own_address,
    input  slave_sda_ack_oe, slave_rx_addr, slave_rd_wr, slave_addr_valid,
           slave_addr_match, slave_selected, slave_busy
  );

endinterface

// File: rtl/slave_bus_sync_edge.sv
// rtl/slave_bus_sync_edge.sv - SCL/SDA synchronizers with registered edge, START and STOP strobes
module slave_bus_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic scl,
  input  logic sda,
  output logic sda_smp,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_ff;
  logic [1:0] sda_ff;
  logic       scl_prev;
  logic       sda_prev;

  // Two-flop synchronizers, one history stage, then registered strobes; idle bus reads as 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_ff    <= 2'b11;
      sda_ff    <= 2'b11;
      scl_prev  <= 1'b1;
      sda_prev  <= 1'b1;
      sda_smp   <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      scl_ff    <= {scl_ff[0], scl};
      sda_ff    <= {sda_ff[0], sda};
      scl_prev  <= scl_ff[1];
      sda_prev  <= sda_ff[1];
      // SDA sample aligned with the strobes so the shifter sees the bit that went with the edge
      sda_smp   <= sda_ff[1];
      scl_rise  <= scl_ff[1] & ~scl_prev;
      scl_fall  <= ~scl_ff[1] & scl_prev;
      start_det <= sda_prev & ~sda_ff[1] & scl_prev & scl_ff[1];
      stop_det  <= ~sda_prev & sda_ff[1] & scl_prev & scl_ff[1];
    end
  end

endmodule

// File: rtl/slave_addr_sipo_match.sv
// rtl/slave_addr_sipo_match.sv - slave address receiver: shifts in the address frame, matches and ACKs
module slave_addr_sipo_match
  import i2c_pkg::*;
#(
  parameter bit GEN_CALL_EN = 1'b0
) (
  input  logic                   slave_scl_sixt,
  input  logic                   slave_rst_n,
  slave_addr_sipo_match_if.slave bus
);

  localparam logic [3:0] LAST_BIT_IDX = 4'(I2C_FRAME_BITS - 1);

  logic sda_smp;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  slave_state_e          state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [7:0]            sr_q, sr_d;
  logic [I2C_ADDR_W-1:0] rx_addr_q, rx_addr_d;
  logic                  rd_wr_q, rd_wr_d;
  logic                  valid_q, valid_d;
  logic                  match_q, match_d;
  logic                  ack_oe_q, ack_oe_d;
  logic                  sel_q, sel_d;
  logic                  busy_q, busy_d;

  logic [7:0]            sr_shift;
  logic                  hit;

  slave_bus_sync_edge u_sync (
    .clk       (slave_scl_sixt),
    .rst_n     (slave_rst_n),
    .scl       (bus.slave_scl),
    .sda       (bus.slave_sda),
    .sda_smp   (sda_smp),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  // The 8th bit is folded in combinationally so address, R/W and match land together with the valid pulse
  assign sr_shift = {sr_q[6:0], sda_smp};
  assign hit      = addr_hit(sr_shift[7:1], bus.slave_own_address, GEN_CALL_EN);

  // State and datapath registers; reset releases SDA immediately
  always_ff @(posedge slave_scl_sixt or negedge slave_rst_n) begin
    if (!slave_rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sr_q      <= '0;
      rx_addr_q <= '0;
      rd_wr_q   <= 1'b0;
      valid_q   <= 1'b0;
      match_q   <= 1'b0;
      ack_oe_q  <= 1'b0;
      sel_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      rx_addr_q <= rx_addr_d;
      rd_wr_q   <= rd_wr_d;
      valid_q   <= valid_d;
      match_q   <= match_d;
      ack_oe_q  <= ack_oe_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state logic: bus conditions override SCL edges; otherwise walk the address/ACK sequence
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    rx_addr_d = rx_addr_q;
    rd_wr_d   = rd_wr_q;
    valid_d   = 1'b0;
    match_d   = match_q;
    ack_oe_d  = ack_oe_q;
    sel_d     = sel_q;
    busy_d    = busy_q;

    if (stop_det) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      match_d  = 1'b0;
      ack_oe_d = 1'b0;
      sel_d    = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      // Also covers repeated START: whoever was selected lets go of the bus here
      state_d  = ST_ADDR;
      cnt_d    = '0;
      sr_d     = '0;
      match_d  = 1'b0;
      ack_oe_d = 1'b0;
      sel_d    = 1'b0;
      busy_d   = 1'b1;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (scl_rise) begin
            sr_d  = sr_shift;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == LAST_BIT_IDX) begin
              rx_addr_d = sr_shift[7:1];
              rd_wr_d   = sr_shift[0];
              match_d   = hit;
              valid_d   = 1'b1;
              state_d   = hit ? ST_ACK_WAIT : ST_IGNORE;
            end
          end
        end
        ST_ACK_WAIT: begin
          if (scl_fall) begin
            ack_oe_d = 1'b1;
            state_d  = ST_ACK;
          end
        end
        ST_ACK: begin
          if (scl_fall) begin
            ack_oe_d = 1'b0;
            sel_d    = 1'b1;
            state_d  = ST_SELECTED;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  assign bus.slave_sda_ack_oe = ack_oe_q;
  assign bus.slave_rx_addr    = rx_addr_q;
  assign bus.slave_rd_wr      = rd_wr_q;
  assign bus.slave_addr_valid = valid_q;
  assign bus.slave_addr_match = match_q;
  assign bus.slave_selected   = sel_q;
  assign bus.slave_busy       = busy_q;

endmodule

// File: doc/slave_addr_sipo_match.md
# slave_addr_sipo_match

Slave-side address receiver: the direct downstream consumer of the master's serial address shifter. Detects START/STOP on the bus, shifts in the 8-bit address frame (7-bit address MSB first, then R/W), compares against the slave's own address and drives the ACK bit on a match. Runs on the slave's 16x-oversampled SCL clock and hands `slave_selected` plus `slave_rd_wr` to the slave data-phase logic.

## Interface
- `GEN_CALL_EN`, 0, when 1 address 7'h00 (general call) also matches
- `slave_scl_sixt`  in  1  16x-oversampled system clock; all flops on its rising edge
- `slave_rst_n`  in  1  asynchronous, active-low reset
- `slave_scl`  in  1  raw bus SCL (asynchronous)
- `slave_sda`  in  1  raw bus SDA (asynchronous)
- `slave_own_address`  in  7  this slave's address, static during a frame
- `slave_sda_ack_oe`  out  1  1 = pull SDA low (ACK); open-drain enable
- `slave_rx_addr`  out  7  last received address
- `slave_rd_wr`  out  1  last received R/W bit (1 = read)
- `slave_addr_valid`  out  1  one-cycle pulse: address frame complete
- `slave_addr_match`  out  1  qualifies `slave_addr_valid`; held until next START/STOP
- `slave_selected`  out  1  addressed and ACK sent; data phase owns the bus
- `slave_busy`  out  1  bus between START and STOP

## Operation
- SCL/SDA pass through 2-flop synchronizers; previous synced values kept for edge detection.
- Events (1-cycle strobes): `scl_rise`, `scl_fall`; START = SDA synced 1→0 while SCL synced high in both samples; STOP = SDA 0→1 while SCL high.
- FSM states: IDLE, ADDR, ACK_WAIT, ACK, SELECTED, IGNORE.
- IDLE: START → ADDR, clear bit counter (4 bits) and shift register.
- ADDR: on each `scl_rise` shift `{sr[6:0], sda}`, increment counter. When counter reaches 8: latch `slave_rx_addr = sr[7:1]`, `slave_rd_wr = sr[0]`, compute match; → ACK_WAIT if match else IGNORE.
- Match = `rx_addr == slave_own_address`, or (`GEN_CALL_EN` and `rx_addr == 0`).
- ACK_WAIT: on `scl_fall` assert `slave_sda_ack_oe` → ACK.
- ACK: hold `slave_sda_ack_oe` through the 9th SCL pulse; on next `scl_fall` deassert → SELECTED.
- SELECTED: `slave_selected = 1`; wait for START/STOP.
- IGNORE: no drive on SDA; wait for START/STOP.
- START in any state (repeated START) → ADDR: counter cleared, `slave_selected`, `slave_addr_match`, `slave_sda_ack_oe` cleared the same cycle.
- STOP in any state → IDLE, same clears; `slave_busy` = 0.
- START/STOP take priority over `scl_rise`/`scl_fall` in the same cycle.
- `slave_busy` set on START, cleared on STOP.

## Timing
- Reset: all outputs 0, FSM IDLE, synchronizers load 1 (idle bus).
- Pin-to-event latency: 3 clocks (2 sync + edge register).
- `slave_addr_valid` pulses the cycle after the 8th `scl_rise`; `slave_rx_addr`, `slave_rd_wr`, `slave_addr_match` valid that same cycle and held.
- `slave_sda_ack_oe` rises 1 clock after the `scl_fall` following bit 8 and falls 1 clock after the next `scl_fall`; `slave_selected` rises with that fall.
- Reset asserted mid-frame: immediate return to reset values, including SDA release.
- Frame shorter than 8 bits ended by START/STOP: no `slave_addr_valid`, no ACK.

## Structure
- Shared package `i2c_pkg`: FSM state enum, `I2C_ADDR_W = 7`, `I2C_FRAME_BITS = 8`, `I2C_GEN_CALL_ADDR = 7'h00`.
- Sub-module `slave_bus_sync_edge`: synchronizers plus `scl_rise`/`scl_fall`/START/STOP strobes; reusable by the slave data-phase SIPO.

## Test plan
- Own 7'h50, frame 0x50+W (0xA0) → `slave_addr_valid` pulse, `rx_addr = 0x50`, `rd_wr = 0`, ACK low across 9th SCL, `slave_selected = 1`.
- Own 7'h50, frame 0x51+R (0xA3) → `addr_match = 0`, `slave_sda_ack_oe` never asserts, `slave_selected = 0`.
- Own 7'h2A, 0x2A+R then repeated START, 0x2B+W → first frame selected with `rd_wr = 1`, selection drops at repeated START, second frame NACKed.
- STOP after 5 address bits → IDLE, `slave_busy = 0`, no `addr_valid`; following full frame 0x50+W ACKed normally.
- `slave_rst_n` pulsed low during ACK → `slave_sda_ack_oe` = 0 asynchronously, all outputs 0, next START accepted.
- `GEN_CALL_EN = 1`, own 7'h50, frame 0x00+W → ACK and `slave_selected = 1`; with `GEN_CALL_EN = 0` → NACK.
